// File: rtl/arm_sram_ctrl.sv
// Wait-state controller splitting 32-bit MEM-stage accesses into narrow SRAM beats.
// Optional feature macro: ARM_SRAM_POSTED_WRITE_EN (one-entry posted-write buffer).
module arm_sram_ctrl #(
   parameter int BASE_ADDR   = 1024,
   parameter int SRAM_AW     = 18,
   parameter int SRAM_DW     = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic               sram_we_n,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in
);

   localparam int         BEATS     = 32 / SRAM_DW;
   localparam logic [1:0] BEAT_LAST = 2'(BEATS - 1);
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t             state_r, state_s;
   logic [1:0]         beat_r, beat_s;
   logic [3:0]         wait_r, wait_s;
   logic [SRAM_AW-1:0] base_r, base_s;
   logic [31:0]        wdata_r, wdata_s;
   logic               write_r, write_s;
   logic [31:0]        rdata_r, rdata_s;
   logic [SRAM_AW-1:0] sram_addr_r, sram_addr_s;
   logic               sram_we_n_r, sram_we_n_s;
   logic [SRAM_DW-1:0] sram_dq_out_r, sram_dq_out_s;
   logic               sram_dq_oe_r, sram_dq_oe_s;
   logic               req_s;
   logic [SRAM_AW-1:0] req_base_s;
   logic [1:0]         beat_inc_s;

   // Select the SRAM_DW-wide lane of a word belonging to beat b (little-endian).
   function automatic logic [SRAM_DW-1:0] beat_slice(input logic [31:0] word, input logic [1:0] b);
      beat_slice = word[SRAM_DW-1:0];
      for (int i = 0; i < BEATS; i++) begin
         beat_slice = (b == 2'(i)) ? word[i*SRAM_DW +: SRAM_DW] : beat_slice;
      end
   endfunction

   // Replace the lane of beat b inside word with d, leaving the other lanes intact.
   function automatic logic [31:0] merge_beat(input logic [31:0] word, input logic [1:0] b,
                                              input logic [SRAM_DW-1:0] d);
      merge_beat = word;
      for (int i = 0; i < BEATS; i++) begin
         merge_beat[i*SRAM_DW +: SRAM_DW] = (b == 2'(i)) ? d : word[i*SRAM_DW +: SRAM_DW];
      end
   endfunction

   assign req_s      = mem_read | mem_write;
   // First SRAM word of the access; upper bits beyond SRAM_AW wrap away.
   assign req_base_s = SRAM_AW'(((addr - 32'(BASE_ADDR)) >> 2) * 32'(BEATS));
   assign beat_inc_s = beat_r + 2'd1;

`ifdef ARM_SRAM_POSTED_WRITE_EN
   logic posted_r, posted_s;

   // Track whether the access in flight is a posted write that owes the pipeline nothing.
   always_comb begin
      posted_s = posted_r;
      case (state_r)
         IDLE:    posted_s = req_s ? mem_write : 1'b0;
         DONE:    posted_s = 1'b0;
         default: posted_s = posted_r;
      endcase
   end

   // Posted-write flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) posted_r <= 1'b0;
      else     posted_r <= posted_s;
   end

   // Writes are accepted at once in IDLE; anything arriving while one drains waits.
   assign ready = (state_r == IDLE) ? (mem_write | ~mem_read)
                                    : ((state_r == DONE) & ~posted_r);
`else
   // Every request blocks until its DONE cycle.
   assign ready = (state_r == IDLE) ? ~req_s : (state_r == DONE);
`endif

   // Next-state and next values of every register, including the SRAM pins.
   always_comb begin
      state_s       = state_r;
      beat_s        = beat_r;
      wait_s        = wait_r;
      base_s        = base_r;
      wdata_s       = wdata_r;
      write_s       = write_r;
      rdata_s       = rdata_r;
      sram_addr_s   = sram_addr_r;
      sram_we_n_s   = 1'b1;
      sram_dq_out_s = sram_dq_out_r;
      sram_dq_oe_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_s) begin
               state_s      = ACCESS;
               beat_s       = 2'd0;
               wait_s       = 4'd0;
               base_s       = req_base_s;
               wdata_s      = wdata;
               write_s      = mem_write;
               sram_addr_s  = req_base_s;
               sram_we_n_s  = ~mem_write;
               sram_dq_oe_s = mem_write;
               if (mem_write) sram_dq_out_s = beat_slice(wdata, 2'd0);
               else           sram_dq_out_s = sram_dq_out_r;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (wait_r == WAIT_LAST) begin
               if (write_r) rdata_s = rdata_r;
               else         rdata_s = merge_beat(rdata_r, beat_r, sram_dq_in);
               if (beat_r == BEAT_LAST) begin
                  state_s = DONE;
               end else begin
                  // Advance to the next beat; pins change together with the address.
                  beat_s       = beat_inc_s;
                  wait_s       = 4'd0;
                  sram_addr_s  = base_r + SRAM_AW'(beat_inc_s);
                  sram_we_n_s  = ~write_r;
                  sram_dq_oe_s = write_r;
                  if (write_r) sram_dq_out_s = beat_slice(wdata_r, beat_inc_s);
                  else         sram_dq_out_s = sram_dq_out_r;
               end
            end else begin
               wait_s       = wait_r + 4'd1;
               sram_we_n_s  = ~write_r;
               sram_dq_oe_s = write_r;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State and datapath registers; reset returns every pin to its idle value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         beat_r        <= 2'd0;
         wait_r        <= 4'd0;
         base_r        <= '0;
         wdata_r       <= 32'd0;
         write_r       <= 1'b0;
         rdata_r       <= 32'd0;
         sram_addr_r   <= '0;
         sram_we_n_r   <= 1'b1;
         sram_dq_out_r <= '0;
         sram_dq_oe_r  <= 1'b0;
      end else begin
         state_r       <= state_s;
         beat_r        <= beat_s;
         wait_r        <= wait_s;
         base_r        <= base_s;
         wdata_r       <= wdata_s;
         write_r       <= write_s;
         rdata_r       <= rdata_s;
         sram_addr_r   <= sram_addr_s;
         sram_we_n_r   <= sram_we_n_s;
         sram_dq_out_r <= sram_dq_out_s;
         sram_dq_oe_r  <= sram_dq_oe_s;
      end
   end

   assign rdata       = rdata_r;
   assign sram_addr   = sram_addr_r;
   assign sram_we_n   = sram_we_n_r;
   assign sram_dq_out = sram_dq_out_r;
   assign sram_dq_oe  = sram_dq_oe_r;

endmodule

// File: tb/tb_arm_sram_ctrl.sv
// Directed bench for arm_sram_ctrl: default 16-bit build plus a 32-bit, zero-wait instance.
// Honours ARM_SRAM_POSTED_WRITE_EN when it is defined for the whole build.
module tb_arm_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic [31:0] rdata;
   logic        ready;
   logic [17:0] sram_addr;
   logic        sram_we_n;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;

   logic        rd32 = 1'b0;
   logic [31:0] addr32 = 32'd0;
   logic [31:0] rdata32;
   logic        ready32;
   logic [17:0] sram_addr32;
   logic        we_n32;
   logic [31:0] dq_out32;
   logic        oe32;
   logic [31:0] dq32_in;

   logic [15:0] mem [0:63];
   logic [7:0]  we_cnt [0:63];
   logic        bd_we = 1'b0;
   logic [5:0]  bd_addr = 6'd0;
   logic [15:0] bd_data = 16'd0;

   int          checks = 0;
   int          failures = 0;
   int          oe_bad = 0;
   int          lat;
   logic [31:0] sb [$];

   always #5 clk = ~clk;

   arm_sram_ctrl dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
      .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
      .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
   );

   arm_sram_ctrl #(.SRAM_DW(32), .WAIT_CYCLES(0)) dut32 (
      .clk(clk), .rst(rst), .mem_read(rd32), .mem_write(1'b0),
      .addr(addr32), .wdata(32'd0), .rdata(rdata32), .ready(ready32),
      .sram_addr(sram_addr32), .sram_we_n(we_n32), .sram_dq_out(dq_out32),
      .sram_dq_oe(oe32), .sram_dq_in(dq32_in)
   );

   // Asynchronous SRAM models
   assign sram_dq_in = mem[sram_addr[5:0]];
   assign dq32_in    = (sram_addr32 == 18'd1) ? 32'hA5A55A5A : 32'h0BAD0BAD;

   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr]    <= bd_data;
         we_cnt[bd_addr] <= 8'd0;
      end else if (!sram_we_n) begin
         mem[sram_addr[5:0]]    <= sram_dq_out;
         we_cnt[sram_addr[5:0]] <= we_cnt[sram_addr[5:0]] + 8'd1;
      end
   end

   always @(negedge clk) begin
      if (sram_dq_oe !== ~sram_we_n) oe_bad <= oe_bad + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One MEM-stage request: push expected rdata, wait for ready, pop and compare.
   task automatic do_req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rdata, input int exp_lat);
      @(negedge clk);
      mem_read = rd; mem_write = wr; addr = a; wdata = d;
      sb.push_back(exp_rdata);
      lat = 0;
      #1;
      while (!ready && lat < 40) begin
         @(negedge clk); #1; lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_rdata"}, rdata, sb.pop_front());
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   int wr_lat;
   int wr_rd_lat;

   initial begin
`ifdef ARM_SRAM_POSTED_WRITE_EN
      wr_lat = 0; wr_rd_lat = 10;
`else
      wr_lat = 5; wr_rd_lat = 5;
`endif
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         bd_we = 1'b1; bd_addr = 6'(i);
         bd_data = (i == 0) ? 16'h5678 : (i == 1) ? 16'h1234 : 16'h0000;
      end
      @(negedge clk); bd_we = 1'b0;
      #1;
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
      chk("rst_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      @(negedge clk); rst = 1'b0;

      do_req("rd1024", 1'b1, 1'b0, 32'd1024, 32'd0, 32'h12345678, 5);
      do_req("wr1032", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h12345678, wr_lat);
      repeat (8) @(negedge clk);
      chk("wr_mem4", 32'(mem[4]), 32'h0000BEEF);
      chk("wr_mem5", 32'(mem[5]), 32'h0000DEAD);
      chk("wr_we_cycles4", 32'(we_cnt[4]), 32'd2);
      chk("wr_we_cycles5", 32'(we_cnt[5]), 32'd2);
      do_req("rd1032", 1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF, 5);

      do_req("rdwr1040", 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 32'hDEADBEEF, wr_lat);
      repeat (8) @(negedge clk);
      chk("rdwr_mem8", 32'(mem[8]), 32'h0000F00D);
      chk("rdwr_mem9", 32'(mem[9]), 32'h0000CAFE);

      // Reset in the second ACCESS cycle of a write
      @(negedge clk);
      mem_write = 1'b1; addr = 32'd1048; wdata = 32'h11112222;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; mem_write = 1'b0;
      #1;
      chk("midrst_we_n", 32'(sram_we_n), 32'd1);
      chk("midrst_oe", 32'(sram_dq_oe), 32'd0);
      chk("midrst_ready", 32'(ready), 32'd1);
      chk("midrst_rdata", rdata, 32'd0);
      chk("midrst_sram_addr", 32'(sram_addr), 32'd0);
      @(negedge clk); rst = 1'b0;
      do_req("rd_after_rst", 1'b1, 1'b0, 32'd1024, 32'd0, 32'h12345678, 5);

      // 32-bit SRAM, zero wait states
      @(negedge clk);
      rd32 = 1'b1; addr32 = 32'd1028;
      sb.push_back(32'hA5A55A5A);
      @(negedge clk); #1;
      lat = 1;
      chk("dw32_sram_addr", 32'(sram_addr32), 32'd1);
      while (!ready32 && lat < 40) begin
         @(negedge clk); #1; lat++;
      end
      chk("dw32_latency", 32'(lat), 32'd2);
      chk("dw32_rdata", rdata32, sb.pop_front());
      @(posedge clk); #1; rd32 = 1'b0;

      // Write immediately followed by a read of the same word
      do_req("wr1064", 1'b0, 1'b1, 32'd1064, 32'h0F0E0D0C, 32'h12345678, wr_lat);
      do_req("rd1064", 1'b1, 1'b0, 32'd1064, 32'd0, 32'h0F0E0D0C, wr_rd_lat);
      repeat (4) @(negedge clk);
      chk("oe_tracks_we_n", 32'(oe_bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
